// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the front-end pipeline control slice.
// The package holds the NOP encoding, the FSM state type and the default control-bundle width.
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          CTRL_W_DEFAULT = 16;

  // The state records the action taken in the previous cycle.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_stall_flush_ctrl_sat_counter.sv
// Saturating event counter with a synchronous, active-low clear.
// Once the count reaches all-ones it holds there and never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Front-end pipeline control: PC, IF/ID and the ID/EX control/valid slice.
// Applies the hazard unit's stall and the EX redirect, and counts both kinds of event.
module pipe_stall_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               CTRL_W   = CTRL_W_DEFAULT,
  parameter int               CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_target_i,
  input  logic [31:0]       instr_f_i,
  input  logic [CTRL_W-1:0] ctrl_d_i,
  output logic [XLEN-1:0]   pc_f_o,
  output logic [31:0]       instr_d_o,
  output logic [XLEN-1:0]   pc_d_o,
  output logic              valid_d_o,
  output logic [4:0]        rs1_d_o,
  output logic [4:0]        rs2_d_o,
  output logic [CTRL_W-1:0] ctrl_e_o,
  output logic              valid_e_o,
  output logic              idex_en_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [XLEN-1:0]   r_pc_f;
  logic [31:0]       r_instr_d;
  logic [XLEN-1:0]   r_pc_d;
  logic              r_valid_d;
  logic [CTRL_W-1:0] r_ctrl_e;
  logic              r_valid_e;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_stall_eff;

  // A stall request against a bubble in ID has nothing to hold, so it is dropped.
  assign w_stall_eff = stall_i & r_valid_d & ~redirect_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = RUN;
    if (redirect_i) begin
      w_state_nxt = FLUSH;
    end else if (w_stall_eff) begin
      w_state_nxt = STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc_f    <= RESET_PC;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
      r_ctrl_e  <= '0;
      r_valid_e <= 1'b0;
    end else if (redirect_i) begin
      r_pc_f    <= redirect_target_i;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
      r_ctrl_e  <= '0;
      r_valid_e <= 1'b0;
    end else if (w_stall_eff) begin
      r_ctrl_e  <= '0;
      r_valid_e <= 1'b0;
    end else begin
      r_pc_f    <= r_pc_f + XLEN'(4);
      r_instr_d <= instr_f_i;
      r_pc_d    <= r_pc_f;
      r_valid_d <= 1'b1;
      r_ctrl_e  <= r_valid_d ? ctrl_d_i : '0;
      r_valid_e <= r_valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_eff),
    .cnt (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_i),
    .cnt (flush_cnt_o)
  );

  // On a redirect the payload still loads; valid_e_o=0 keeps it inert.
  assign idex_en_o = ~(w_stall_eff & rst);
  assign rs1_d_o   = r_valid_d ? r_instr_d[19:15] : 5'd0;
  assign rs2_d_o   = r_valid_d ? r_instr_d[24:20] : 5'd0;

  assign pc_f_o    = r_pc_f;
  assign instr_d_o = r_instr_d;
  assign pc_d_o    = r_pc_d;
  assign valid_d_o = r_valid_d;
  assign ctrl_e_o  = r_ctrl_e;
  assign valid_e_o = r_valid_e;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Directed, table-driven bench for pipe_stall_flush_ctrl (CNT_W=4 to reach saturation quickly).
// Each vector gives the inputs for one cycle and the expected state after the following edge.
module tb_pipe_stall_flush_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [15:0] CTRL  = 16'hA5C3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] instr_f_i;
  logic [15:0] ctrl_d_i;
  logic [31:0] pc_f_o;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic        valid_d_o;
  logic [4:0]  rs1_d_o;
  logic [4:0]  rs2_d_o;
  logic [15:0] ctrl_e_o;
  logic        valid_e_o;
  logic        idex_en_o;
  logic [1:0]  state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stall_flush_ctrl #(
    .XLEN(32), .RESET_PC(32'h0), .CTRL_W(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .instr_f_i(instr_f_i), .ctrl_d_i(ctrl_d_i),
    .pc_f_o(pc_f_o), .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .valid_d_o(valid_d_o),
    .rs1_d_o(rs1_d_o), .rs2_d_o(rs2_d_o), .ctrl_e_o(ctrl_e_o), .valid_e_o(valid_e_o),
    .idex_en_o(idex_en_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_idex;
    logic [31:0] exp_pc_f;
    logic [31:0] exp_pc_d;
    logic        exp_vd;
    logic        exp_ve;
    logic [1:0]  exp_st;
    logic [3:0]  exp_sc;
    logic [3:0]  exp_fc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] t, logic ie,
                              logic [31:0] pf, logic [31:0] pd, logic vd, logic ve,
                              logic [1:0] st, logic [3:0] sc, logic [3:0] fc);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = d; v.tgt = t; v.exp_idex = ie;
    v.exp_pc_f = pf; v.exp_pc_d = pd; v.exp_vd = vd; v.exp_ve = ve;
    v.exp_st = st; v.exp_sc = sc; v.exp_fc = fc;
    return v;
  endfunction

  // Fetched word encodes rs1/rs2 from the fetch PC so the ID-stage fields are traceable.
  function automatic logic [31:0] mk_instr(logic [31:0] p);
    logic [4:0] a;
    a = p[6:2];
    return {7'd0, 5'(a + 5'd1), a, 3'b000, 5'd1, 7'h33};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(string tag, vec_t v);
    logic [31:0] e_instr;
    e_instr = v.exp_vd ? mk_instr(v.exp_pc_d) : NOP;
    chk({tag, " pc_f"},    pc_f_o,             v.exp_pc_f);
    chk({tag, " valid_d"}, 32'(valid_d_o),     32'(v.exp_vd));
    chk({tag, " valid_e"}, 32'(valid_e_o),     32'(v.exp_ve));
    chk({tag, " ctrl_e"},  32'(ctrl_e_o),      v.exp_ve ? 32'(CTRL) : 32'd0);
    chk({tag, " state"},   32'(state_o),       32'(v.exp_st));
    chk({tag, " stall_cnt"}, 32'(stall_cnt_o), 32'(v.exp_sc));
    chk({tag, " flush_cnt"}, 32'(flush_cnt_o), 32'(v.exp_fc));
    chk({tag, " instr_d"}, instr_d_o,          e_instr);
    chk({tag, " rs1"},     32'(rs1_d_o),       v.exp_vd ? 32'(e_instr[19:15]) : 32'd0);
    chk({tag, " rs2"},     32'(rs2_d_o),       v.exp_vd ? 32'(e_instr[24:20]) : 32'd0);
    if (v.exp_vd) chk({tag, " pc_d"}, pc_d_o, v.exp_pc_d);
  endtask

  initial begin
    logic [31:0] cur_pc;
    vec_t        rv;

    // rst stall redir tgt  idex pc_f  pc_d  vd ve st sc fc
    vecs[0]  = mk(1, 0, 0, 32'h0,   1, 32'h4,   32'h0,   1, 0, 2'd1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,   1, 32'h8,   32'h4,   1, 1, 2'd1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,   1, 32'hC,   32'h8,   1, 1, 2'd1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,   0, 32'hC,   32'h8,   1, 0, 2'd2, 1, 0);
    vecs[4]  = mk(1, 0, 0, 32'h0,   1, 32'h10,  32'hC,   1, 1, 2'd1, 1, 0);
    vecs[5]  = mk(1, 1, 1, 32'h100, 1, 32'h100, 32'h0,   0, 0, 2'd3, 1, 1);
    vecs[6]  = mk(1, 1, 0, 32'h0,   1, 32'h104, 32'h100, 1, 0, 2'd1, 1, 1);
    vecs[7]  = mk(1, 0, 0, 32'h0,   1, 32'h108, 32'h104, 1, 1, 2'd1, 1, 1);
    vecs[8]  = mk(1, 1, 0, 32'h0,   0, 32'h108, 32'h104, 1, 0, 2'd2, 2, 1);
    vecs[9]  = mk(1, 1, 0, 32'h0,   0, 32'h108, 32'h104, 1, 0, 2'd2, 3, 1);
    vecs[10] = mk(0, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 0, 2'd0, 0, 0);
    vecs[11] = mk(1, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 2'd3, 0, 1);
    vecs[12] = mk(1, 0, 0, 32'h0,   1, 32'h0,   32'hFFFF_FFFC, 1, 0, 2'd1, 0, 1);
    vecs[13] = mk(1, 0, 0, 32'h0,   1, 32'h4,   32'h0,   1, 1, 2'd1, 0, 1);

    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_target_i = '0; instr_f_i = '0; ctrl_d_i = CTRL;

    // Reset: held for two edges, with a stall request that must be discarded.
    stall_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset idex_en", 32'(idex_en_o), 32'd1);
    rv = mk(0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0, 2'd0, 0, 0);
    check_state("reset", rv);
    cur_pc = 32'h0;

    for (int i = 0; i < 14; i++) begin
      rst               = vecs[i].rst_n;
      stall_i           = vecs[i].stall;
      redirect_i        = vecs[i].redir;
      redirect_target_i = vecs[i].tgt;
      instr_f_i         = mk_instr(cur_pc);
      #1;
      chk($sformatf("v%0d idex_en", i), 32'(idex_en_o), 32'(vecs[i].exp_idex));
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i]);
      cur_pc = vecs[i].exp_pc_f;
    end

    // Long stall: the 4-bit stall counter must stop at 15 while PC and ID hold.
    rst = 1'b1; stall_i = 1'b1; redirect_i = 1'b0; instr_f_i = mk_instr(cur_pc);
    for (int i = 1; i <= 20; i++) begin
      #1;
      chk($sformatf("sat%0d idex_en", i), 32'(idex_en_o), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d stall_cnt", i), 32'(stall_cnt_o), (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("sat%0d pc_f", i), pc_f_o, 32'h4);
      chk($sformatf("sat%0d pc_d", i), pc_d_o, 32'h0);
      chk($sformatf("sat%0d valid_e", i), 32'(valid_e_o), 32'd0);
      chk($sformatf("sat%0d state", i), 32'(state_o), 32'd2);
    end

    // Release the stall: the held instruction moves on to EX.
    stall_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post-sat pc_f", pc_f_o, 32'h8);
    chk("post-sat valid_e", 32'(valid_e_o), 32'd1);
    chk("post-sat stall_cnt", 32'(stall_cnt_o), 32'd15);
    chk("post-sat state", 32'(state_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_flush_ctrl.md
# pipe_stall_flush_ctrl

Front-end pipeline control block that acts on the hazard unit's load-use stall request and the EX-stage redirect. It owns the PC register, the IF/ID register and the control/valid slice of the ID/EX register. It holds, bubbles or squashes these registers so the hazard unit's decisions take effect cycle-exactly. It also returns the ID-stage source register fields that the hazard unit compares against, and keeps saturating stall and flush event counters.

## Interface
Parameters:
- XLEN, 32, PC and target width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 16, width of the decoded ID control bundle carried into EX
- CNT_W, 32, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; rst is synchronous, active-low
- stall_i  in  1  load-use stall request from the hazard unit
- redirect_i  in  1  taken branch or jump resolved in EX
- redirect_target_i  in  XLEN  next fetch PC when redirect_i=1
- instr_f_i  in  32  instruction fetched at pc_f_o
- ctrl_d_i  in  CTRL_W  decoder control bundle for the instruction in ID
- pc_f_o  out  XLEN  current fetch PC
- instr_d_o  out  32  IF/ID instruction
- pc_d_o  out  XLEN  IF/ID PC
- valid_d_o  out  1  IF/ID holds a real instruction
- rs1_d_o, rs2_d_o  out  5  instr_d_o[19:15], instr_d_o[24:20]; 0 when valid_d_o=0
- ctrl_e_o  out  CTRL_W  ID/EX control bundle
- valid_e_o  out  1  ID/EX holds a real instruction
- idex_en_o  out  1  load enable for the ID/EX data payload registers kept elsewhere
- state_o  out  2  FSM state encoding
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- stall_eff = stall_i & valid_d_o & ~redirect_i. A stall request against a bubble in ID is ignored.
- Priority, highest first: reset, redirect, stall_eff, advance.
- Redirect:
  - pc_f_o <= redirect_target_i.
  - IF/ID <= NOP (32'h0000_0013), valid_d_o <= 0.
  - ctrl_e_o <= 0, valid_e_o <= 0.
  - flush_cnt_o increments.
- Stall:
  - pc_f_o and IF/ID hold.
  - ctrl_e_o <= 0, valid_e_o <= 0 (bubble).
  - idex_en_o = 0.
  - stall_cnt_o increments.
- Advance:
  - pc_f_o <= pc_f_o + 4.
  - IF/ID <= {instr_f_i, pc_f_o}; valid_d_o <= 1.
  - ctrl_e_o <= valid_d_o ? ctrl_d_i : 0; valid_e_o <= valid_d_o.
  - idex_en_o = 1.
- idex_en_o is combinational: 1 unless stall_eff. On redirect it stays 1 and the payload loads, but valid_e_o=0 makes that payload inert.
- FSM (state_o): BOOT=0, RUN=1, STALL=2, FLUSH=3. The state records the action taken in the previous cycle.
  - BOOT: entered on reset. Goes to FLUSH on redirect, otherwise RUN. Stall is impossible here because valid_d_o=0.
  - Any state: redirect -> FLUSH; stall_eff -> STALL; otherwise -> RUN.
- Counters saturate at all-ones and never wrap.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
- redirect_target_i is taken unmodified; alignment is not checked.

## Timing
- All state updates happen on the rising clock edge. The only combinational outputs are idex_en_o and rs1_d_o/rs2_d_o.
- Reset values:
  - pc_f_o=RESET_PC, instr_d_o=NOP, pc_d_o=0, valid_d_o=0.
  - ctrl_e_o=0, valid_e_o=0.
  - state_o=BOOT, both counters 0.
- idex_en_o reads 1 while rst=0.
- Reset asserted mid-stall or mid-flush wins in that same edge. Pending stall and redirect requests are discarded.
- A stall lasts exactly as long as stall_eff is high, one bubble per cycle.
- Load-use case: a single stall cycle lets the hazard unit forward from WB on the following cycle.
- Redirect and stall in the same cycle: the redirect wins, no stall is counted, flush_cnt increments by 1.
- After a redirect, the first valid instruction reaches ID two edges later and EX three edges later.

## Structure
- Shared package pipe_ctrl_pkg contains:
  - the NOP_INSTR constant (32'h0000_0013);
  - the FSM state typedef/localparams BOOT/RUN/STALL/FLUSH;
  - the default CTRL_W.
- Sub-module sat_counter #(W), with inc, clk, rst and cnt ports, is instantiated twice.

## Test plan
- Reset release with RESET_PC=0, no requests:
  - pc_f_o sequences 0,4,8,12.
  - valid_d_o rises one edge after release; valid_e_o rises two edges after release.
  - state goes BOOT->RUN.
- Load-use, stall_i=1 for one cycle with valid_d_o=1 and pc_d_o=8:
  - pc_f_o holds at 12 and pc_d_o holds at 8 for one edge.
  - valid_e_o=0 for one cycle, idex_en_o=0, stall_cnt_o=1, state=STALL.
- Redirect to 32'h100 while stall_i=1:
  - pc_f_o=32'h100, valid_d_o=0, valid_e_o=0.
  - flush_cnt_o=1, stall_cnt_o unchanged, state=FLUSH.
- stall_i=1 while valid_d_o=0 (just after a flush):
  - Ignored: PC advances, stall_cnt_o unchanged.
- rst=0 asserted during a 3-cycle stall:
  - All outputs return to their reset values on that edge; the counters clear.
- CNT_W=4 with 20 stall cycles:
  - stall_cnt_o saturates at 15.
  - pc_f_o=32'hFFFF_FFFC then advance -> 0.
